// File: rtl/acc_reg_file_ctx.sv
// Accumulator + register file with a shadow bank for multi-cycle context save/restore (optional ACC_BYPASS_EN write forwarding).
// Reads are combinational; a save/restore holds Busy for R+1 cycles and then pulses Done; writes and requests arriving while Busy are dropped.
module acc_reg_file_ctx #(
   parameter int W = 8,
   parameter int D = 3
) (
   input  logic         Clk,
   input  logic         Reset_n,
   input  logic         WriteEn,
   input  logic         Destination,
   input  logic [D-1:0] Waddr,
   input  logic [D-1:0] RaddrB,
   input  logic [W-1:0] DataIn,
   output logic [W-1:0] DataOutA,
   output logic [W-1:0] DataOutB,
   input  logic         SaveReq,
   input  logic         RestoreReq,
   output logic         Busy,
   output logic         Done,
   output logic         ShadowValid,
   output logic         RestoreErr
);

   localparam int R  = 2 ** D;
   localparam int N  = R + 1;
   localparam int IW = $clog2(N);
   localparam logic [IW-1:0] LAST_IDX = IW'(R);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SAVE,
      ST_RESTORE
   } state_t;

   state_t          r_state, w_state_nxt;
   logic [IW-1:0]   r_idx, w_idx_nxt;
   logic            r_done, w_done_nxt;
   logic            r_err, w_err_nxt;
   logic            r_sv, w_sv_nxt;

   logic [W-1:0]    r_acc;
   logic [W-1:0]    r_regs   [R];
   logic [W-1:0]    r_shadow [N];

   logic            w_busy;
   logic            w_last;
   logic            w_wr;
   logic [D-1:0]    w_reg_idx;
   logic [W-1:0]    w_live_entry;
   logic [W-1:0]    w_shadow_entry;

   assign w_busy         = (r_state != ST_IDLE);
   assign w_last         = (r_idx == LAST_IDX);
   assign w_wr           = WriteEn && !w_busy;
   // Entry 0 is the accumulator; entry i maps to Registers[i-1].
   assign w_reg_idx      = D'(r_idx - IW'(1));
   assign w_live_entry   = (r_idx == '0) ? r_acc : r_regs[w_reg_idx];
   assign w_shadow_entry = r_shadow[r_idx];

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_state <= ST_IDLE;
         r_idx   <= '0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
         r_sv    <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
         r_done  <= w_done_nxt;
         r_err   <= w_err_nxt;
         r_sv    <= w_sv_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      w_done_nxt  = 1'b0;
      w_err_nxt   = 1'b0;
      w_sv_nxt    = r_sv;
      case (r_state)
         ST_IDLE: begin
            if (SaveReq) begin
               w_state_nxt = ST_SAVE;
               w_idx_nxt   = '0;
               // The bank is about to be partially overwritten, so it is no longer a full snapshot.
               w_sv_nxt    = 1'b0;
            end else if (RestoreReq) begin
               if (r_sv) begin
                  w_state_nxt = ST_RESTORE;
                  w_idx_nxt   = '0;
               end else begin
                  w_err_nxt = 1'b1;
               end
            end
         end
         ST_SAVE: begin
            if (w_last) begin
               w_state_nxt = ST_IDLE;
               w_idx_nxt   = '0;
               w_done_nxt  = 1'b1;
               w_sv_nxt    = 1'b1;
            end else begin
               w_idx_nxt = r_idx + IW'(1);
            end
         end
         ST_RESTORE: begin
            if (w_last) begin
               w_state_nxt = ST_IDLE;
               w_idx_nxt   = '0;
               w_done_nxt  = 1'b1;
            end else begin
               w_idx_nxt = r_idx + IW'(1);
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_idx_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_acc <= '0;
         for (int i = 0; i < R; i++) r_regs[i] <= '0;
      end else if (r_state == ST_RESTORE) begin
         if (r_idx == '0) r_acc <= w_shadow_entry;
         else             r_regs[w_reg_idx] <= w_shadow_entry;
      end else if (w_wr) begin
         if (!Destination) r_acc <= DataIn;
         else              r_regs[Waddr] <= DataIn;
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         for (int i = 0; i < N; i++) r_shadow[i] <= '0;
      end else if (r_state == ST_SAVE) begin
         r_shadow[r_idx] <= w_live_entry;
      end
   end

`ifdef ACC_BYPASS_EN
   assign DataOutA = (w_wr && !Destination) ? DataIn : r_acc;
   assign DataOutB = (w_wr && Destination && (Waddr == RaddrB)) ? DataIn : r_regs[RaddrB];
`else
   assign DataOutA = r_acc;
   assign DataOutB = r_regs[RaddrB];
`endif

   assign Busy        = w_busy;
   assign Done        = r_done;
   assign ShadowValid = r_sv;
   assign RestoreErr  = r_err;

endmodule

// File: doc/acc_reg_file_ctx.md
Name: acc_reg_file_ctx

Overview:
Parametrised accumulator-plus-register-file, the next generation of the core register file.
- Accumulator on read port A; general registers on read port B; single write port steered by Destination.
- Adds a shadow bank with multi-cycle context save/restore, sequenced by an FSM with Busy/Done handshake.
- Sits in the datapath between decode and ALU; save/restore is driven by the controller on interrupt/call boundaries.

Parameters:
W, 8, data path width.
D, 3, register pointer width; general register count R = 2**D.

Ports:
Clk  input  1  system clock, rising edge.
Reset_n  input  1  asynchronous active-low reset.
WriteEn  input  1  write strobe.
Destination  input  1  0 = accumulator, 1 = Registers[Waddr].
Waddr  input  D  general register write address.
RaddrB  input  D  general register read address.
DataIn  input  W  write data.
DataOutA  output  W  accumulator value, combinational.
DataOutB  output  W  Registers[RaddrB], combinational.
SaveReq  input  1  request snapshot of accumulator and all registers into shadow bank.
RestoreReq  input  1  request copy of shadow bank back into live registers.
Busy  output  1  save/restore in progress.
Done  output  1  one-cycle pulse on completion.
ShadowValid  output  1  shadow bank holds a complete snapshot.
RestoreErr  output  1  one-cycle pulse: restore requested with ShadowValid = 0.

Behaviour:
- Clock and reset: one clock (Clk); reset (Reset_n) is asynchronous and active-low.
- Reset values: Accumulator, all Registers and all shadow entries = 0; ShadowValid = 0; Busy = 0; Done = 0; RestoreErr = 0; FSM = IDLE; index = 0.
- Reads: combinational. DataOutA = Accumulator; DataOutB = Registers[RaddrB]. The new value is visible after the write edge.
- Writes: on a rising edge with WriteEn = 1 and Busy = 0. Destination selects the accumulator or Registers[Waddr].
  - Writes with Busy = 1 are silently dropped.
- Entries: N = R+1 entries, indexed 0..R. Index 0 = accumulator; index i = Registers[i-1].
- FSM states: IDLE, SAVE, RESTORE.
  - IDLE, SaveReq = 1: go to SAVE, index = 0. SaveReq has priority over RestoreReq.
  - IDLE, RestoreReq = 1, ShadowValid = 1: go to RESTORE, index = 0.
  - IDLE, RestoreReq = 1, ShadowValid = 0: stay in IDLE; RestoreErr pulses next cycle; no state change.
  - SAVE: each edge copies live entry[index] to shadow[index] and increments index. On the edge copying index R, go to IDLE and set ShadowValid = 1.
  - RESTORE: each edge copies shadow[index] to live entry[index]. On the last copy, go to IDLE; ShadowValid stays 1, so the snapshot is reusable.
  - SaveReq/RestoreReq are ignored while Busy.
- Timing: request accepted at edge E0.
  - Busy = 1 from E0 until EN; copies occur at edges E1..EN.
  - At EN, Busy falls and Done = 1 for exactly one cycle.
  - Back-to-back: a new request seen in that Done cycle is accepted at EN+1.
- Same-cycle write and accept: a write in the accepting cycle (Busy = 0) commits at E0. The snapshot therefore includes it.
- Abort on SAVE: a SAVE aborted by reset leaves ShadowValid = 0.
- Reads during RESTORE: return the partially restored live state.
- Reset mid-operation: returns immediately to reset values, including shadow contents and ShadowValid.
- No arithmetic; index counter is ceil(log2(R+1)) bits and never exceeds R.

Optional Feature:
ACC_BYPASS_EN.
- Defined: a write in the same cycle is forwarded to the outputs combinationally. Applies when WriteEn = 1 and Busy = 0.
  - DataOutA = DataIn when Destination = 0.
  - DataOutB = DataIn when Destination = 1 and Waddr == RaddrB.
- Not defined: outputs show pre-edge stored values only.
- Sequential behaviour is identical in both builds.

Test Plan:
- Reset_n = 0 mid-run, then released → DataOutA = 0x00, DataOutB = 0x00 for all RaddrB, Busy = 0, ShadowValid = 0.
- Write acc = 0x5A, then R3 = 0xC3; RaddrB = 3 → DataOutA = 0x5A, DataOutB = 0xC3 one cycle after each write edge.
- Load acc = 0x11 and R0..R7 = 0x20..0x27; pulse SaveReq → Busy high 9 cycles, Done pulse, ShadowValid = 1. Then overwrite all with 0xFF and pulse RestoreReq → after 9 cycles acc = 0x11 and R5 = 0x25.
- During SAVE, WriteEn with Destination = 1, Waddr = 2, DataIn = 0x99 → dropped, R2 unchanged. Repeat the write in the accept cycle → 0x99 is present after restore.
- RestoreReq right after reset → RestoreErr pulses 1 cycle, Busy stays 0, registers unchanged. SaveReq and RestoreReq together in IDLE → SAVE taken.
- With ACC_BYPASS_EN, write R4 = 0x77 with RaddrB = 4 → DataOutB = 0x77 in the same cycle. Without the macro → old value until the edge.
